// File: rtl/pc_unit.sv
// pc_unit: SimpleRISC fetch PC with prioritised next-PC select and a circular return-address stack.
// Define PC_MISALIGN_TRAP_EN to send misaligned targets to TRAP_VEC instead of masking bits [1:0].
module pc_unit #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
    parameter int INC = 4,
    parameter int RAS_DEPTH = 4
`ifdef PC_MISALIGN_TRAP_EN
    , parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0010
`endif
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_target,
    input  logic            i_branch_taken,
    input  logic [XLEN-1:0] i_branch_target,
    input  logic            i_call,
    input  logic            i_ret,
    input  logic [XLEN-1:0] i_ret_fallback,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_plus,
    output logic            o_ras_empty,
    output logic            o_ras_full,
    output logic            o_ras_overflow,
    output logic            o_ras_underflow,
    output logic            o_misalign
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0]   r_top;
    logic [CW-1:0]   r_cnt;
    logic            r_ovf;
    logic            r_unf;
    logic            r_mis;

    logic [XLEN-1:0] w_pc_plus;
    logic [XLEN-1:0] w_tgt;
    logic [XLEN-1:0] w_next;
    logic [PW-1:0]   w_top_inc;
    logic            w_empty;
    logic            w_full;
    logic            w_act;
    logic            w_use_tgt;
    logic            w_mis;

    assign w_pc_plus = r_pc + XLEN'(INC);
    assign w_top_inc = r_top + 1'b1;
    assign w_empty   = r_cnt == '0;
    assign w_full    = r_cnt == CW'(RAS_DEPTH);
    assign w_act     = !i_redirect_valid && !i_stall;

    always_comb begin
        w_use_tgt = i_redirect_valid || i_ret || i_branch_taken;
        w_tgt = i_redirect_valid ? i_redirect_target :
                i_ret ? (w_empty ? i_ret_fallback : r_ras[r_top]) : i_branch_target;
`ifdef PC_MISALIGN_TRAP_EN
        w_mis  = w_use_tgt && (w_tgt[1:0] != 2'b00);
        w_next = !w_use_tgt ? w_pc_plus : w_mis ? TRAP_VEC : w_tgt;
`else
        w_mis  = 1'b0;
        w_next = w_use_tgt ? (w_tgt & ~XLEN'(3)) : w_pc_plus;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc  <= RESET_VEC;
            r_top <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            r_mis <= 1'b0;
        end else begin
            r_unf <= 1'b0;
            r_mis <= 1'b0;
            if (i_redirect_valid || !i_stall) begin
                r_pc  <= w_next;
                r_mis <= w_mis;
            end
            if (w_act) begin
                r_unf <= i_ret && w_empty;
                // call+ret on a non-empty stack swaps the top entry in place
                if (i_call && i_ret && !w_empty) begin
                    r_ras[r_top] <= w_pc_plus;
                end else if (i_call) begin
                    r_ras[w_top_inc] <= w_pc_plus;
                    r_top <= w_top_inc;
                    if (w_full) r_ovf <= 1'b1;
                    else r_cnt <= r_cnt + 1'b1;
                end else if (i_ret && !w_empty) begin
                    r_top <= r_top - 1'b1;
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    assign o_pc            = r_pc;
    assign o_pc_plus       = w_pc_plus;
    assign o_ras_empty     = w_empty;
    assign o_ras_full      = w_full;
    assign o_ras_overflow  = r_ovf;
    assign o_ras_underflow = r_unf;
    assign o_misalign      = r_mis;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed checks of pc_unit priority, RAS nesting, overflow/underflow, wrap and target alignment.
// Observed state per check is {pc, empty, full, overflow, underflow, misalign}.
module tb_pc_unit;
    logic        clk = 1'b0;
    logic        rst, stall, rv, bt, call, ret;
    logic [31:0] rt, btg, rf;
    logic [31:0] pc, pc_plus;
    logic        empty, full, ovf, unf, mis;
    logic [36:0] obs;
    logic [36:0] exp_v;
    int checks = 0;
    int errors = 0;

    pc_unit dut (
        .i_clk(clk), .i_rst(rst), .i_stall(stall),
        .i_redirect_valid(rv), .i_redirect_target(rt),
        .i_branch_taken(bt), .i_branch_target(btg),
        .i_call(call), .i_ret(ret), .i_ret_fallback(rf),
        .o_pc(pc), .o_pc_plus(pc_plus), .o_ras_empty(empty), .o_ras_full(full),
        .o_ras_overflow(ovf), .o_ras_underflow(unf), .o_misalign(mis)
    );

    always #5 clk = ~clk;
    assign obs = {pc, empty, full, ovf, unf, mis};

    task automatic idle();
        rst = 0; stall = 0; rv = 0; rt = 0; bt = 0; btg = 0; call = 0; ret = 0; rf = 32'h3000;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        step();
        step();
        checks++; if (obs !== {32'h0, 5'b10000}) begin errors++; $display("FAIL reset got %h exp %h", obs, {32'h0, 5'b10000}); end
        rst = 0;
        step();
        checks++; if (obs !== {32'h4, 5'b10000}) begin errors++; $display("FAIL inc1 got %h exp %h", obs, {32'h4, 5'b10000}); end
        step();
        checks++; if (obs !== {32'h8, 5'b10000}) begin errors++; $display("FAIL inc2 got %h exp %h", obs, {32'h8, 5'b10000}); end
        step();
        checks++; if (obs !== {32'hC, 5'b10000}) begin errors++; $display("FAIL inc3 got %h exp %h", obs, {32'hC, 5'b10000}); end
        checks++; if (pc_plus !== 32'h10) begin errors++; $display("FAIL pc_plus got %h exp %h", pc_plus, 32'h10); end
        rst = 1;
        step();
        rst = 0;
        stall = 1;
        step();
        checks++; if (obs !== {32'h0, 5'b10000}) begin errors++; $display("FAIL stall1 got %h exp %h", obs, {32'h0, 5'b10000}); end
        step();
        checks++; if (obs !== {32'h0, 5'b10000}) begin errors++; $display("FAIL stall2 got %h exp %h", obs, {32'h0, 5'b10000}); end
        stall = 0;
    endtask

    task automatic test_priority();
        do_reset();
        rv = 1; rt = 32'h1C;
        step();
        rv = 0;
        call = 1; bt = 1; btg = 32'h20;
        step();
        call = 0; bt = 0;
        checks++; if (obs !== {32'h20, 5'b00000}) begin errors++; $display("FAIL prio_setup got %h exp %h", obs, {32'h20, 5'b00000}); end
        rv = 1; rt = 32'h100; bt = 1; btg = 32'h40; ret = 1; stall = 1;
        step();
        checks++; if (obs !== {32'h100, 5'b00000}) begin errors++; $display("FAIL prio_redirect got %h exp %h", obs, {32'h100, 5'b00000}); end
        rv = 0; ret = 0;
        step();
        checks++; if (obs !== {32'h100, 5'b00000}) begin errors++; $display("FAIL prio_stall got %h exp %h", obs, {32'h100, 5'b00000}); end
        stall = 0; bt = 0; ret = 1;
        step();
        ret = 0;
        checks++; if (obs !== {32'h20, 5'b10000}) begin errors++; $display("FAIL prio_ras_kept got %h exp %h", obs, {32'h20, 5'b10000}); end
    endtask

    task automatic test_call_ret();
        do_reset();
        rv = 1; rt = 32'h10;
        step();
        rv = 0;
        call = 1; bt = 1; btg = 32'h80;
        step();
        checks++; if (obs !== {32'h80, 5'b00000}) begin errors++; $display("FAIL call1 got %h exp %h", obs, {32'h80, 5'b00000}); end
        call = 0; bt = 0;
        step();
        call = 1; bt = 1; btg = 32'hC0;
        step();
        call = 0; bt = 0;
        step();
        call = 1; bt = 1; btg = 32'h200;
        step();
        checks++; if (obs !== {32'h200, 5'b00000}) begin errors++; $display("FAIL call3 got %h exp %h", obs, {32'h200, 5'b00000}); end
        call = 0; bt = 0; ret = 1;
        step();
        checks++; if (obs !== {32'hC8, 5'b00000}) begin errors++; $display("FAIL ret1 got %h exp %h", obs, {32'hC8, 5'b00000}); end
        step();
        checks++; if (obs !== {32'h88, 5'b00000}) begin errors++; $display("FAIL ret2 got %h exp %h", obs, {32'h88, 5'b00000}); end
        step();
        checks++; if (obs !== {32'h14, 5'b10000}) begin errors++; $display("FAIL ret3 got %h exp %h", obs, {32'h14, 5'b10000}); end
        ret = 0;
        step();
        checks++; if (obs !== {32'h18, 5'b10000}) begin errors++; $display("FAIL nest_end got %h exp %h", obs, {32'h18, 5'b10000}); end
    endtask

    task automatic test_overflow();
        logic [31:0] e;
        do_reset();
        call = 1; bt = 1;
        for (int i = 0; i < 5; i++) begin
            btg = 32'h100 * (i + 1);
            step();
            if (i == 3) begin
                checks++; if (obs !== {32'h400, 5'b01000}) begin errors++; $display("FAIL full4 got %h exp %h", obs, {32'h400, 5'b01000}); end
            end
        end
        call = 0; bt = 0;
        checks++; if (obs !== {32'h500, 5'b01100}) begin errors++; $display("FAIL overflow got %h exp %h", obs, {32'h500, 5'b01100}); end
        ret = 1; rf = 32'h3000;
        for (int i = 0; i < 4; i++) begin
            step();
            e = 32'h404 - 32'h100 * i;
            exp_v = {e, (i == 3), 1'b0, 1'b1, 1'b0, 1'b0};
            checks++; if (obs !== exp_v) begin errors++; $display("FAIL ovf_ret%0d got %h exp %h", i, obs, exp_v); end
        end
        step();
        checks++; if (obs !== {32'h3000, 5'b10110}) begin errors++; $display("FAIL underflow got %h exp %h", obs, {32'h3000, 5'b10110}); end
        ret = 0;
        step();
        checks++; if (obs !== {32'h3004, 5'b10100}) begin errors++; $display("FAIL unf_pulse got %h exp %h", obs, {32'h3004, 5'b10100}); end
    endtask

    task automatic test_wrap_call_ret();
        do_reset();
        rv = 1; rt = 32'hFFFF_FFFC;
        step();
        rv = 0;
        checks++; if (pc_plus !== 32'h0) begin errors++; $display("FAIL wrap_plus got %h exp %h", pc_plus, 32'h0); end
        step();
        checks++; if (obs !== {32'h0, 5'b10000}) begin errors++; $display("FAIL wrap got %h exp %h", obs, {32'h0, 5'b10000}); end
        call = 1; bt = 1; btg = 32'h4FC;
        step();
        btg = 32'h40;
        step();
        checks++; if (obs !== {32'h40, 5'b00000}) begin errors++; $display("FAIL cr_setup got %h exp %h", obs, {32'h40, 5'b00000}); end
        bt = 0; ret = 1;
        step();
        checks++; if (obs !== {32'h500, 5'b00000}) begin errors++; $display("FAIL call_ret got %h exp %h", obs, {32'h500, 5'b00000}); end
        call = 0;
        step();
        checks++; if (obs !== {32'h44, 5'b00000}) begin errors++; $display("FAIL cr_top got %h exp %h", obs, {32'h44, 5'b00000}); end
        step();
        checks++; if (obs !== {32'h4, 5'b10000}) begin errors++; $display("FAIL cr_count got %h exp %h", obs, {32'h4, 5'b10000}); end
        call = 1;
        step();
        checks++; if (obs !== {32'h3000, 5'b00010}) begin errors++; $display("FAIL cr_empty got %h exp %h", obs, {32'h3000, 5'b00010}); end
        call = 0;
        step();
        ret = 0;
        checks++; if (obs !== {32'h8, 5'b10000}) begin errors++; $display("FAIL cr_push got %h exp %h", obs, {32'h8, 5'b10000}); end
    endtask

    task automatic test_misalign();
        do_reset();
        bt = 1; btg = 32'h102;
        step();
        bt = 0;
`ifdef PC_MISALIGN_TRAP_EN
        checks++; if (obs !== {32'h10, 5'b10001}) begin errors++; $display("FAIL mis_trap got %h exp %h", obs, {32'h10, 5'b10001}); end
        step();
        checks++; if (obs !== {32'h14, 5'b10000}) begin errors++; $display("FAIL mis_pulse got %h exp %h", obs, {32'h14, 5'b10000}); end
`else
        checks++; if (obs !== {32'h100, 5'b10000}) begin errors++; $display("FAIL mis_mask got %h exp %h", obs, {32'h100, 5'b10000}); end
        step();
        checks++; if (obs !== {32'h104, 5'b10000}) begin errors++; $display("FAIL mis_next got %h exp %h", obs, {32'h104, 5'b10000}); end
`endif
    endtask

    initial begin
        idle();
        test_reset();
        test_priority();
        test_call_ret();
        test_overflow();
        test_wrap_call_ret();
        test_misalign();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised next-generation program counter for the SimpleRISC core fetch stage.
- Holds the architectural PC and selects the next PC from these sources:
  - sequential increment
  - branch or call target
  - return-address stack (RAS) pop
  - external redirect (interrupt or exception)
- Supports fetch stall.
- Contains a DEPTH-entry circular RAS so `ret` resolves without a register-file read.

Parameters:
- XLEN, 32, PC and target width in bits.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- INC, 4, byte increment per sequential instruction.
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2).
- TRAP_VEC, 32'h0000_0010, PC loaded on misaligned target (optional feature only).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- stall  in  1  hold PC and RAS unchanged.
- redirect_valid  in  1  external redirect (interrupt/exception).
- redirect_target  in  XLEN  redirect PC.
- branch_taken  in  1  taken branch or call/jump this cycle.
- branch_target  in  XLEN  branch/call target.
- call  in  1  current instruction is a call; push return address.
- ret  in  1  current instruction is a return; pop RAS.
- ret_fallback  in  XLEN  return address from `ra`, used when RAS is empty.
- pc  out  XLEN  current PC.
- pc_plus  out  XLEN  pc + INC (combinational).
- ras_empty  out  1  RAS count == 0.
- ras_full  out  1  RAS count == RAS_DEPTH.
- ras_overflow  out  1  sticky: a push occurred while full; cleared only by reset.
- ras_underflow  out  1  one-cycle pulse: a ret was taken with RAS empty.
- misalign  out  1  one-cycle pulse (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (synchronous, active-high; `rst` is sampled only on the clk edge):
  - pc = RESET_VEC.
  - RAS count = 0, top pointer = 0, entries are don't-care.
  - ras_overflow = 0, ras_underflow = 0, misalign = 0.
  - `rst` overrides every other input in the same cycle.
- Next-PC priority, highest first:
  1. rst
  2. redirect_valid: pc ← redirect_target. RAS untouched, even if call/ret are asserted.
  3. stall: pc, RAS and flags held. Pulse outputs go to 0.
  4. ret: pc ← RAS top if not empty, else ret_fallback with ras_underflow = 1 next cycle.
  5. branch_taken: pc ← branch_target.
  6. Otherwise: pc ← pc + INC, wrapping modulo 2^XLEN with no carry out.
- Latency: a new pc is visible one cycle after the inputs are sampled. pc_plus follows pc combinationally.
- RAS push (call asserted, not stalled, no redirect):
  - Writes pc + INC at top+1 and advances top.
  - count increments, saturating at RAS_DEPTH.
  - Push while full overwrites the oldest entry (circular) and sets ras_overflow.
- RAS pop (ret asserted, not stalled, no redirect, count > 0): reads entry at top, decrements top and count.
- call and ret in the same cycle:
  - pc ← popped value (or ret_fallback if empty).
  - Top entry is replaced in place by pc + INC; count unchanged.
  - If empty, this is a plain push of pc + INC, count becomes 1, and ras_underflow pulses.
- call with branch_taken: pc ← branch_target and push. call without branch_taken is a protocol error; the push still occurs and pc increments.
- Pointers wrap modulo RAS_DEPTH. Overflow loses the oldest entry only.
- Reset mid-sequence discards all RAS contents. There is no partial state after reset.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - Any selected redirect, branch or ret target with bits [1:0] ≠ 0 loads TRAP_VEC instead.
  - misalign pulses 1 for the cycle after the load.
  - The RAS push/pop for that cycle still takes effect.
- Undefined:
  - Target bits [1:0] are forced to 0 before loading.
  - misalign is constant 0 and TRAP_VEC is unused.

Test Plan:
- Reset/increment: rst=1 for 2 cycles, then 3 idle cycles → pc = 0x0, 0x4, 0x8, 0xC. Deassert rst with stall=1 for 2 cycles → pc holds 0x0.
- Priority: at pc=0x20, assert redirect_valid(0x100), branch_taken(0x40), ret, stall together → pc = 0x100 and RAS count unchanged. Next cycle, stall with branch_taken → pc holds 0x100.
- Call/return nesting:
  - Calls at pc 0x10→0x80, 0x84→0xC0, 0xC4→0x200.
  - Rets then yield 0xC8, 0x88, 0x14.
  - ras_empty=1 at the end; no underflow pulse.
- Overflow/underflow (RAS_DEPTH=4):
  - 5 nested calls → ras_overflow=1, ras_full=1.
  - 5 rets → the first 4 return the newest addresses.
  - The 5th returns ret_fallback=0x3000 with ras_underflow=1 for exactly one cycle.
- Wrap and simultaneous call+ret:
  - pc=0xFFFF_FFFC idle → pc = 0x0.
  - With RAS top = 0x500 at pc=0x40, assert call+ret → pc = 0x500, top becomes 0x44, count unchanged.
- Optional feature: branch_target = 0x102.
  - With PC_MISALIGN_TRAP_EN → pc = 0x10 and misalign=1 for one cycle.
  - Without → pc = 0x100 and misalign=0.
